alu_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit ALU: fetches 16-bit instructions from program memory, drives them onto the ALU's `k` bus and supplies its operands. It holds the accumulator, a 4-entry register file and the carry/zero flags, and sequences data-memory load/store handshakes and conditional jumps. It sits between program/data memory and the combinational ALU, whose `x`, `y`, `k`, `cf` and `dm` inputs it drives and whose `q`, `cl` and `zl` outputs it consumes.

---
 rtl/alu_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/execute control unit wrapped around a
// combinational 8-bit ALU. Holds pc, ir, acc, r0-r3, mdr and the carry/zero
// flags, and runs the program/data memory handshakes.
// Optional build macro: SEQ_TIMEOUT_EN enables a TMO-cycle handshake timeout
// that drops the request, raises err and halts. Without it err is always 0.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | pm_rd high, waiting for pm_ack
// EXEC   | ir decoded, ALU result sampled at the end of the cycle
// MEM    | dm_req high, waiting for dm_ack
// WB     | load data in mdr presented on dm, acc/zf written back
// HALT   | halt instruction or timeout, waiting for start

module alu_sequencer #(
    parameter int TMO = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  pm_addr,
    output logic        pm_rd,
    input  logic [15:0] pm_data,
    input  logic        pm_ack,
    output logic [7:0]  dm_addr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [7:0]  dm_wdata,
    input  logic [7:0]  dm_rdata,
    input  logic        dm_ack,
    output logic [15:0] k,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        cf,
    output logic [7:0]  dm,
    input  logic [7:0]  q,
    input  logic        cl,
    input  logic        zl,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic [7:0]  acc_q;
    logic [7:0]  rf_q [4];
    logic [7:0]  mdr_q;
    logic        cf_q;
    logic        zf_q;
    logic [7:0]  dm_addr_q;
    logic        dm_we_q;
    logic [7:0]  dm_wdata_q;
    logic        pm_rd_q;
    logic        dm_req_q;
    logic        busy_q;
    logic        halted_q;
    logic        err_q;
    logic        jump_taken_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
    logic [CW-1:0] tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
`endif

    // Jump condition from ir[9:8] against the current flags.
    always_comb begin
        jump_taken_d = 1'b0;
        case (ir_q[9:8])
            2'd0:    jump_taken_d = 1'b1;
            2'd1:    jump_taken_d = zf_q;
            2'd2:    jump_taken_d = cf_q;
            default: jump_taken_d = ~zf_q;
        endcase
    end

    // Sequencer: state, architectural registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            acc_q      <= '0;
            rf_q       <= '{default: '0};
            mdr_q      <= '0;
            cf_q       <= 1'b0;
            zf_q       <= 1'b0;
            dm_addr_q  <= '0;
            dm_we_q    <= 1'b0;
            dm_wdata_q <= '0;
            pm_rd_q    <= 1'b0;
            dm_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q     <= '0;
                        err_q    <= 1'b0;
                        pm_rd_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
`ifdef SEQ_TIMEOUT_EN
                        tmo_q    <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (pm_ack) begin
                        ir_q    <= pm_data;
                        pc_q    <= pc_q + 8'd1;
                        pm_rd_q <= 1'b0;
                        state_q <= S_EXEC;
`ifdef SEQ_TIMEOUT_EN
                        tmo_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        pm_rd_q  <= 1'b0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                S_EXEC: begin
                    // Most opcodes return straight to FETCH; memory and halt override below.
                    state_q <= S_FETCH;
                    pm_rd_q <= 1'b1;
                    case (ir_q[15:12])
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                            acc_q <= q;
                            cf_q  <= cl;
                            zf_q  <= zl;
                        end
                        4'h8: begin
                            if (ir_q[2:0] <= 3'd5) begin
                                acc_q <= q;
                                cf_q  <= cl;
                                zf_q  <= zl;
                            end
                        end
                        4'h9: begin
                            case (ir_q[1:0])
                                2'd0, 2'd1: begin
                                    acc_q <= q;
                                    cf_q  <= cl;
                                    zf_q  <= zl;
                                end
                                2'd2: begin
                                    acc_q <= q;
                                    zf_q  <= zl;
                                end
                                default: ;
                            endcase
                        end
                        4'hA: begin
                            dm_addr_q <= ir_q[11:4];
                            dm_we_q   <= ir_q[0];
                            if (ir_q[0]) begin
                                dm_wdata_q <= q;
                            end
                            pm_rd_q  <= 1'b0;
                            dm_req_q <= 1'b1;
                            state_q  <= S_MEM;
                        end
                        4'hB: begin
                            if (jump_taken_d) begin
                                pc_q <= ir_q[7:0];
                            end
                        end
                        4'hC: rf_q[ir_q[5:4]] <= acc_q;
                        4'hF: begin
                            pm_rd_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dm_ack) begin
                        dm_req_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        tmo_q    <= '0;
`endif
                        if (dm_we_q) begin
                            pm_rd_q <= 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            mdr_q   <= dm_rdata;
                            state_q <= S_WB;
                        end
`ifdef SEQ_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        dm_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                S_WB: begin
                    // ALU passes dm (=mdr) through for a load; carry is left alone.
                    acc_q   <= q;
                    zf_q    <= zl;
                    pm_rd_q <= 1'b1;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pm_addr  = pc_q;
    assign pm_rd    = pm_rd_q;
    assign dm_addr  = dm_addr_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_wdata = dm_wdata_q;
    assign k        = ir_q;
    assign x        = acc_q;
    assign y        = rf_q[ir_q[5:4]];
    assign cf       = cf_q;
    assign dm       = mdr_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small combinational ALU, memory responders with
// configurable/random wait states, an instruction-level reference model checked
// at every fetch and data handshake, a directed program table and random programs.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pm_addr;
    logic        pm_rd;
    logic [15:0] pm_data = '0;
    logic        pm_ack = 1'b0;
    logic [7:0]  dm_addr;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_wdata;
    logic [7:0]  dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic [15:0] k;
    logic [7:0]  x, y, dm, q;
    logic        cf, cl, zl;
    logic        busy, halted, err;

    always #5 clk = ~clk;

    alu_sequencer #(.TMO(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data), .pm_ack(pm_ack),
        .dm_addr(dm_addr), .dm_req(dm_req), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .k(k), .x(x), .y(y), .cf(cf), .dm(dm), .q(q), .cl(cl), .zl(zl),
        .busy(busy), .halted(halted), .err(err)
    );

    // Environment ALU: returns {zero, carry, result}.
    function automatic logic [9:0] alu_f(logic [15:0] kk, logic [7:0] xx, logic [7:0] yy,
                                         logic cc, logic [7:0] dd);
        logic [8:0] s;
        logic [7:0] r;
        logic c;
        c = 1'b0;
        r = xx;
        case (kk[15:12])
            4'h0: r = yy;
            4'h1: begin s = {1'b0, xx} + {1'b0, kk[7:0]}; {c, r} = s; end
            4'h2: begin s = {1'b0, xx} + {1'b0, yy}; {c, r} = s; end
            4'h3: begin s = {1'b0, xx} - {1'b0, kk[7:0]}; {c, r} = s; end
            4'h4: r = xx & kk[7:0];
            4'h5: r = xx ^ yy;
            4'h8: begin
                case (kk[2:0])
                    3'd0: {c, r} = {xx, 1'b0};
                    3'd1: {r, c} = {1'b0, xx};
                    3'd2: {r, c} = {xx[7], xx};
                    3'd3: begin r = {xx[6:0], xx[7]}; c = xx[7]; end
                    3'd4: begin r = {xx[0], xx[7:1]}; c = xx[0]; end
                    3'd5: r = {xx[3:0], xx[7:4]};
                    default: r = xx;
                endcase
            end
            4'h9: begin
                case (kk[1:0])
                    2'd0: {c, r} = {xx, cc};
                    2'd1: {r, c} = {cc, xx};
                    2'd2: r = ~xx;
                    default: r = xx;
                endcase
            end
            4'hA: r = kk[0] ? xx : dd;
            default: r = xx;
        endcase
        return {r == 8'h00, c, r};
    endfunction

    always_comb {zl, cl, q} = alu_f(k, x, y, cf, dm);

    // ---------------- memories and responders ----------------
    logic [15:0] pmem [256];
    logic [7:0]  dmem [256];
    int  pwait = 0, dwait = 0, pcnt = 0, dcnt = 0, pw = 0, dw = 0;
    bit  rand_mode = 1'b0, pm_ack_en = 1'b1, force_dack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (pm_rd && pm_ack_en) begin
            if (pcnt >= pw) begin
                pm_ack = 1'b1;
                pm_data = pmem[pm_addr];
            end else begin
                pm_ack = 1'b0;
                pcnt++;
            end
        end else begin
            pm_ack = 1'b0;
            pcnt = 0;
            pw = rand_mode ? int'($urandom_range(0, 2)) : pwait;
        end
        if (force_dack) begin
            dm_ack = 1'b1;
            dm_rdata = 8'h55;
        end else if (dm_req) begin
            if (dcnt >= dw) begin
                dm_ack = 1'b1;
                dm_rdata = dmem[dm_addr];
                if (dm_we) dmem[dm_addr] = dm_wdata;
            end else begin
                dm_ack = 1'b0;
                dcnt++;
            end
        end else begin
            dm_ack = 1'b0;
            dcnt = 0;
            dw = rand_mode ? int'($urandom_range(0, 2)) : dwait;
        end
    end

    // ---------------- checking ----------------
    int vectors = 0, miscompares = 0;

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level reference model (architectural state only).
    typedef struct { logic [7:0] a; logic we; logic [7:0] d; } mem_t;
    mem_t        expq [$];
    logic [7:0]  mpc, macc, mr [4], mdmem [256];
    logic [15:0] mir;
    logic        mcf, mzf;
    bit          mrun, mhalt;

    task automatic mdl_exec(logic [15:0] w);
        logic [9:0] r;
        logic [7:0] a;
        logic tk;
        mpc = mpc + 8'd1;
        mir = w;
        r = alu_f(w, macc, mr[w[5:4]], mcf, 8'h00);
        case (w[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: {mzf, mcf, macc} = r;
            4'h8: if (w[2:0] <= 3'd5) {mzf, mcf, macc} = r;
            4'h9: begin
                if (w[1:0] < 2'd2) {mzf, mcf, macc} = r;
                else if (w[1:0] == 2'd2) begin macc = r[7:0]; mzf = r[9]; end
            end
            4'hA: begin
                a = w[11:4];
                if (w[0]) begin
                    expq.push_back('{a, 1'b1, macc});
                    mdmem[a] = macc;
                end else begin
                    expq.push_back('{a, 1'b0, 8'h00});
                    macc = mdmem[a];
                    mzf = (macc == 8'h00);
                end
            end
            4'hB: begin
                case (w[9:8])
                    2'd0: tk = 1'b1;
                    2'd1: tk = mzf;
                    2'd2: tk = mcf;
                    default: tk = !mzf;
                endcase
                if (tk) mpc = w[7:0];
            end
            4'hC: mr[w[5:4]] = macc;
            4'hF: begin mrun = 1'b0; mhalt = 1'b1; end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mpc = '0; macc = '0; mir = '0; mcf = 1'b0; mzf = 1'b0;
            mr = '{default: 8'h00};
            mrun = 1'b0; mhalt = 1'b0;
            expq.delete();
            for (int a = 0; a < 256; a++) mdmem[a] = dmem[a];
        end else begin
            if (start && !mrun) begin
                mrun = 1'b1; mhalt = 1'b0; mpc = '0;
            end
            if (pm_rd && pm_ack) begin
                chk("fetch_pc", pm_addr, mpc);
                chk("fetch_x", x, macc);
                chk("fetch_cf", cf, mcf);
                chk("fetch_y", y, mr[mir[5:4]]);
                chk("fetch_k", k, mir);
                mdl_exec(pm_data);
            end
            if (dm_req && dm_ack) begin
                if (expq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL dm_unexpected: got addr %h expected no request", dm_addr);
                end else begin
                    mem_t e;
                    e = expq.pop_front();
                    chk("dm_addr", dm_addr, e.a);
                    chk("dm_we", dm_we, e.we);
                    if (e.we) chk("dm_wdata", dm_wdata, e.d);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic reset_dut();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (halted) break;
            if (cyc >= 3000) begin
                vectors++; miscompares++;
                $display("FAIL halt_wait: got no halt after %0d cycles expected halted=1", cyc);
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] p0, p1, p2, p3;
        logic [7:0]  dval;
        int          pw, dw;
        logic [7:0]  ex;
        logic        ecf;
        logic [7:0]  epc;
        int          ecyc;
    } vec_t;

    vec_t vt [14];

    initial begin
        int cyc, n;
        vt[0]  = '{16'h1005, 16'h10FF, 16'hF000, 16'hF000, 8'h00, 0, 0, 8'h04, 1'b1, 8'h03, 6};
        vt[1]  = '{16'hA300, 16'hC010, 16'hA401, 16'hF000, 8'h00, 0, 0, 8'h00, 1'b0, 8'h04, 11};
        vt[2]  = '{16'h4000, 16'hB120, 16'hF000, 16'hF000, 8'h00, 0, 0, 8'h00, 1'b0, 8'h21, 6};
        vt[3]  = '{16'h1001, 16'hB120, 16'hF000, 16'hF000, 8'h00, 0, 0, 8'h01, 1'b0, 8'h03, 6};
        vt[4]  = '{16'h1001, 16'hB320, 16'hF000, 16'hF000, 8'h00, 0, 0, 8'h01, 1'b0, 8'h21, 6};
        vt[5]  = '{16'h4000, 16'hB320, 16'hF000, 16'hF000, 8'h00, 0, 0, 8'h00, 1'b0, 8'h03, 6};
        vt[6]  = '{16'h10FF, 16'h1001, 16'hB220, 16'hF000, 8'h00, 0, 0, 8'h00, 1'b1, 8'h21, 8};
        vt[7]  = '{16'h1005, 16'h10FF, 16'hF000, 16'hF000, 8'h00, 1, 0, 8'h04, 1'b1, 8'h03, 9};
        vt[8]  = '{16'h1081, 16'h9000, 16'hF000, 16'hF000, 8'h00, 0, 0, 8'h02, 1'b1, 8'h03, 6};
        vt[9]  = '{16'h10FF, 16'h1001, 16'h9002, 16'hF000, 8'h00, 0, 0, 8'hFF, 1'b1, 8'h04, 8};
        vt[10] = '{16'h1005, 16'h8006, 16'h8001, 16'hF000, 8'h00, 0, 0, 8'h02, 1'b1, 8'h04, 8};
        vt[11] = '{16'hA300, 16'hC020, 16'h2020, 16'hF000, 8'h7E, 0, 2, 8'hFC, 1'b0, 8'h04, 12};
        vt[12] = '{16'h1033, 16'hA501, 16'h4000, 16'hA500, 8'h00, 0, 0, 8'h33, 1'b0, 8'h05, 13};
        vt[13] = '{16'h1010, 16'h3011, 16'hD000, 16'h6000, 8'h00, 0, 0, 8'hFF, 1'b1, 8'h05, 10};

        for (int a = 0; a < 256; a++) begin pmem[a] = 16'hF000; dmem[a] = 8'h00; end

        // Reset state.
        reset_dut();
        chk("rst_pm_addr", pm_addr, 0); chk("rst_pm_rd", pm_rd, 0);
        chk("rst_dm_req", dm_req, 0);   chk("rst_dm_we", dm_we, 0);
        chk("rst_dm_addr", dm_addr, 0); chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_k", k, 0); chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_cf", cf, 0);
        chk("rst_dm", dm, 0); chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);

        // Directed program table.
        for (int i = 0; i < 14; i++) begin
            for (int a = 0; a < 256; a++) begin pmem[a] = 16'hF000; dmem[a] = vt[i].dval; end
            pmem[0] = vt[i].p0; pmem[1] = vt[i].p1; pmem[2] = vt[i].p2; pmem[3] = vt[i].p3;
            pwait = vt[i].pw; dwait = vt[i].dw;
            reset_dut();
            start_pulse();
            wait_halt(cyc);
            chk($sformatf("tbl%0d_x", i), x, vt[i].ex);
            chk($sformatf("tbl%0d_cf", i), cf, vt[i].ecf);
            chk($sformatf("tbl%0d_pc", i), pm_addr, vt[i].epc);
            chk($sformatf("tbl%0d_cycles", i), cyc, vt[i].ecyc);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
        end
        pwait = 0; dwait = 0;

        // Fetch wait states: request held with stable address, ir loaded only on ack.
        for (int a = 0; a < 256; a++) pmem[a] = 16'hF000;
        pmem[0] = 16'h1005;
        pwait = 3;
        reset_dut();
        start_pulse();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!pm_rd) break;
            n++;
            chk("ws_pm_addr", pm_addr, 0);
            chk("ws_k_hold", k, 0);
        end
        chk("ws_rd_cycles", n, 4);
        chk("ws_k_capture", k, 16'h1005);
        wait_halt(cyc);
        chk("ws_x", x, 8'h05);
        pwait = 0;

        // Reset in the middle of a load handshake; a late ack must be ignored.
        pmem[0] = 16'hA300;
        dwait = 5;
        reset_dut();
        start_pulse();
        n = 0;
        while (!dm_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("rm_req_seen", dm_req, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rm_dm_req", dm_req, 0); chk("rm_pm_rd", pm_rd, 0); chk("rm_dm_addr", dm_addr, 0);
        chk("rm_k", k, 0); chk("rm_pm_addr", pm_addr, 0); chk("rm_busy", busy, 0);
        chk("rm_halted", halted, 0); chk("rm_x", x, 0);
        rst_n = 1'b1;
        force_dack = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_dack = 1'b0;
        chk("rm_late_dm", dm, 0); chk("rm_late_busy", busy, 0); chk("rm_late_x", x, 0);
        dwait = 0;

`ifdef SEQ_TIMEOUT_EN
        // Fetch that is never acknowledged.
        reset_dut();
        pm_ack_en = 1'b0;
        start_pulse();
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!pm_rd) break;
            n++;
        end
        chk("tmo_rd_cycles", n, 16);
        @(posedge clk); #1;
        chk("tmo_err", err, 1); chk("tmo_halted", halted, 1);
        start_pulse();
        chk("tmo_err_clear", err, 0);
        reset_dut();
        pm_ack_en = 1'b1;
`endif

        // Random forward-only programs with random wait states.
        rand_mode = 1'b1;
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 256; a++) begin pmem[a] = 16'hF000; dmem[a] = 8'($urandom); end
            for (int i = 0; i < 39; i++) begin
                logic [3:0] op;
                logic [15:0] w;
                op = 4'($urandom_range(0, 14));
                w = {op, 12'($urandom)};
                if (op == 4'hB) w[7:0] = 8'($urandom_range(i + 1, 39));
                pmem[i] = w;
            end
            reset_dut();
            start_pulse();
            wait_halt(cyc);
            chk("rnd_x", x, macc);
            chk("rnd_cf", cf, mcf);
            chk("rnd_halted", halted, 16'(mhalt));
            chk("rnd_mem_pending", 16'(expq.size()), 0);
        end
        rand_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
